// File: rtl/iopage_ctl.sv
// I/O page initiator: turns CPU transfers in the top 8 KB of 22-bit space into iopage_* cycles.
// Latency: read ack 2 cycles after accept, write ack 3; NXM pulse NXM_TIMEOUT+1 cycles after accept.
// Backpressure: one transfer in flight; cpu_req is only sampled in IDLE, so the CPU must hold or retry.
module iopage_ctl #(
  parameter int NXM_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [21:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic        cpu_byte_op,
  input  logic [15:0] cpu_data_out,
  output logic [15:0] cpu_data_in,
  output logic        cpu_ack,
  output logic        cpu_nxm,
  output logic [12:0] iopage_addr,
  output logic [15:0] iopage_data_out,
  output logic        iopage_rd,
  output logic        iopage_wr,
  output logic        iopage_byte_op,
  input  logic [15:0] iopage_data_in,
  input  logic        iopage_decode
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  // Counter value seen in the last no-decode cycle before giving up.
  localparam logic [7:0] CNT_LAST = 8'(NXM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [12:0] addr_q;
  logic [15:0] wdat_q;
  logic        byte_q;
  logic        wr_q;
  logic [7:0]  cnt_q;
  logic [15:0] rdat_q;

  logic        hit;
  logic        accept;
  logic [15:0] wdat_steer;
  logic [15:0] rdat_steer;

  assign hit    = (cpu_addr[21:13] == 9'o777);
  assign accept = cpu_req && hit && (cpu_rd || cpu_wr);

  // Byte writes replicate the low byte so the device can pick either lane.
  assign wdat_steer = cpu_byte_op ? {cpu_data_out[7:0], cpu_data_out[7:0]} : cpu_data_out;

  // Byte reads return the addressed lane right-justified and zero-extended.
  always_comb begin
    rdat_steer = iopage_data_in;
    if (byte_q) begin
      rdat_steer = addr_q[0] ? {8'h00, iopage_data_in[15:8]} : {8'h00, iopage_data_in[7:0]};
    end
  end

  // State, request latches, no-decode counter and read-data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdat_q  <= '0;
      byte_q  <= 1'b0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && accept) begin
        addr_q <= cpu_addr[12:0];
        wdat_q <= wdat_steer;
        byte_q <= cpu_byte_op;
        wr_q   <= cpu_wr;
        cnt_q  <= '0;
      end else if (state_q == S_ADDR && !iopage_decode) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (state_q == S_ADDR && iopage_decode && !wr_q) begin
        rdat_q <= rdat_steer;
      end
    end
  end

  // Next-state and bus strobes; everything idles at zero outside an active transfer.
  always_comb begin
    state_d         = state_q;
    iopage_addr     = '0;
    iopage_data_out = '0;
    iopage_rd       = 1'b0;
    iopage_wr       = 1'b0;
    iopage_byte_op  = 1'b0;
    cpu_ack         = 1'b0;
    cpu_nxm         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_ADDR;
      end
      S_ADDR: begin
        iopage_addr     = addr_q;
        iopage_byte_op  = byte_q;
        iopage_rd       = !wr_q;
        iopage_data_out = wr_q ? wdat_q : 16'h0000;
        if (iopage_decode) begin
          state_d = wr_q ? S_WRITE : S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
        end
      end
      S_WRITE: begin
        iopage_addr     = addr_q;
        iopage_byte_op  = byte_q;
        iopage_data_out = wdat_q;
        iopage_wr       = 1'b1;
        state_d         = S_DONE;
      end
      S_DONE: begin
        cpu_ack = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        cpu_nxm = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cpu_data_in = rdat_q;

endmodule

// File: tb/tb_iopage_ctl.sv
// Scoreboard bench for iopage_ctl: driver issues transfers and queues expected responses/strobes,
// a negedge monitor pops and compares; a simple device model answers decode after a chosen delay.
module tb_iopage_ctl;
  localparam int N = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [21:0] cpu_addr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic        cpu_byte_op;
  logic [15:0] cpu_data_out;
  logic [15:0] cpu_data_in;
  logic        cpu_ack;
  logic        cpu_nxm;
  logic [12:0] iopage_addr;
  logic [15:0] iopage_data_out;
  logic        iopage_rd;
  logic        iopage_wr;
  logic        iopage_byte_op;
  logic [15:0] iopage_data_in;
  logic        iopage_decode;

  iopage_ctl #(.NXM_TIMEOUT(N)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_byte_op(cpu_byte_op), .cpu_data_out(cpu_data_out),
    .cpu_data_in(cpu_data_in), .cpu_ack(cpu_ack), .cpu_nxm(cpu_nxm),
    .iopage_addr(iopage_addr), .iopage_data_out(iopage_data_out),
    .iopage_rd(iopage_rd), .iopage_wr(iopage_wr), .iopage_byte_op(iopage_byte_op),
    .iopage_data_in(iopage_data_in), .iopage_decode(iopage_decode)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {bit nxm; logic [15:0] data; bit chk; int at;} rsp_t;
  typedef struct {logic [12:0] addr; logic [15:0] data; bit bop; int at;} wre_t;
  rsp_t rsp_q[$];
  wre_t wre_q[$];

  bit          mon_en = 1'b0;
  bit          active = 1'b0;
  bit          cur_rd;
  logic [12:0] cur_addr;
  bit          cur_bop;
  int          cur_t0;
  int          cur_rd_last;
  int          rel;
  logic        dev_dec = 1'b0;

  // Device model: the switch-register-like word at 0o17570, a pattern elsewhere.
  function automatic logic [15:0] dev_data(input logic [12:0] a);
    if ({a[12:1], 1'b0} == 13'o17570) return 16'o123456;
    return {a[12:1], 4'ha} ^ 16'h3c5a;
  endfunction

  function automatic logic [15:0] rd_expect(input logic [12:0] a, input bit bop);
    logic [15:0] w;
    w = dev_data(a);
    if (!bop) return w;
    return a[0] ? {8'h00, w[15:8]} : {8'h00, w[7:0]};
  endfunction

  assign iopage_decode  = dev_dec;
  assign iopage_data_in = dev_dec ? dev_data(iopage_addr) : 16'h0000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares responses and strobes against the queues and the current transfer.
  always @(negedge clk) begin
    if (mon_en) begin
      if (cpu_ack || cpu_nxm) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_rsp", {62'd0, cpu_ack, cpu_nxm}, 64'd0);
        end else begin
          rsp_t r;
          r = rsp_q.pop_front();
          chk("rsp_cycle", 64'(cyc), 64'(r.at));
          chk("rsp_kind", {62'd0, cpu_ack, cpu_nxm}, r.nxm ? 64'd1 : 64'd2);
          if (r.chk && cpu_ack) chk("rd_data", 64'(cpu_data_in), 64'(r.data));
        end
      end
      if (active) begin
        rel = cyc - cur_t0;
        chk("iopage_rd", 64'(iopage_rd), 64'(cur_rd && rel >= 1 && rel <= cur_rd_last));
        if (iopage_rd) begin
          chk("rd_addr", 64'(iopage_addr), 64'(cur_addr));
          chk("rd_byte_op", 64'(iopage_byte_op), 64'(cur_bop));
        end
        if (iopage_wr) begin
          if (wre_q.size() == 0) begin
            chk("unexpected_wr", 64'(iopage_wr), 64'd0);
          end else begin
            wre_t w;
            w = wre_q.pop_front();
            chk("wr_cycle", 64'(cyc), 64'(w.at));
            chk("wr_addr", 64'(iopage_addr), 64'(w.addr));
            chk("wr_data", 64'(iopage_data_out), 64'(w.data));
            chk("wr_byte_op", 64'(iopage_byte_op), 64'(w.bop));
          end
        end
      end else begin
        chk("idle_outs", {30'd0, iopage_rd, iopage_wr, iopage_byte_op, iopage_addr,
                          iopage_data_out, cpu_ack, cpu_nxm}, 64'd0);
      end
    end
  end

  task automatic garble_cpu();
    cpu_req      = 1'($urandom);
    cpu_addr     = 22'($urandom);
    cpu_rd       = 1'($urandom);
    cpu_wr       = 1'($urandom);
    cpu_byte_op  = 1'($urandom);
    cpu_data_out = 16'($urandom);
  endtask

  task automatic quiet_cpu();
    cpu_req = 1'b0; cpu_addr = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    cpu_byte_op = 1'b0; cpu_data_out = '0;
  endtask

  // Issue one transfer in the current (IDLE) cycle; dly = cycle of first decode, 0 or >N = never.
  task automatic xfer(input logic [21:0] a, input bit rd, input bit wr, input bit bop,
                      input logic [15:0] d, input int dly);
    bit acc;
    bit decoded;
    int r;
    int t0;
    rsp_t rs;
    wre_t we;
    t0 = cyc;
    acc = (a[21:13] == 9'o777) && (rd || wr);
    decoded = (dly >= 1) && (dly <= N);
    cpu_req = 1'b1; cpu_addr = a; cpu_rd = rd; cpu_wr = wr;
    cpu_byte_op = bop; cpu_data_out = d;
    r = 4;
    if (acc) begin
      cur_rd = !wr; cur_addr = a[12:0]; cur_bop = bop; cur_t0 = t0;
      cur_rd_last = decoded ? dly : N;
      if (!decoded) begin
        r = N + 1;
        rs = '{nxm: 1'b1, data: 16'h0, chk: 1'b0, at: t0 + r};
      end else if (wr) begin
        r = dly + 2;
        we = '{addr: a[12:0], data: bop ? {d[7:0], d[7:0]} : d, bop: bop, at: t0 + dly + 1};
        wre_q.push_back(we);
        rs = '{nxm: 1'b0, data: 16'h0, chk: 1'b0, at: t0 + r};
      end else begin
        r = dly + 1;
        rs = '{nxm: 1'b0, data: rd_expect(a[12:0], bop), chk: 1'b1, at: t0 + r};
      end
      rsp_q.push_back(rs);
      active = 1'b1;
    end
    for (int k = 1; k <= r; k++) begin
      @(negedge clk); #1;
      if (acc) garble_cpu(); else quiet_cpu();
      dev_dec = acc && decoded && (k >= dly);
    end
    active = 1'b0;
    dev_dec = 1'b0;
    quiet_cpu();
    @(negedge clk); #1;
    chk("rsp_outstanding", 64'(rsp_q.size()), 64'd0);
    chk("wr_outstanding", 64'(wre_q.size()), 64'd0);
    rsp_q.delete();
    wre_q.delete();
  endtask

  // Write accepted, then reset in its first ADDR cycle while the device decodes.
  task automatic reset_mid_write();
    cpu_req = 1'b1; cpu_addr = 22'o17777570; cpu_rd = 1'b0; cpu_wr = 1'b1;
    cpu_byte_op = 1'b0; cpu_data_out = 16'hbeef;
    cur_rd = 1'b0; cur_addr = 13'o17570; cur_bop = 1'b0; cur_t0 = cyc; cur_rd_last = 0;
    active = 1'b1;
    @(negedge clk); #1;
    quiet_cpu();
    reset = 1'b1;
    dev_dec = 1'b1;
    active = 1'b0;
    @(negedge clk); #1;
    chk("rst_data_in", 64'(cpu_data_in), 64'd0);
    @(negedge clk); #1;
    reset = 1'b0;
    dev_dec = 1'b0;
    repeat (3) @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    quiet_cpu();
    repeat (2) @(negedge clk);
    #1;
    mon_en = 1'b1;
    chk("reset_data_in", 64'(cpu_data_in), 64'd0);
    chk("reset_ack_nxm", {62'd0, cpu_ack, cpu_nxm}, 64'd0);
    @(negedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;

    xfer(22'o17777570, 1, 0, 0, 16'h0, 1);      // word read
    xfer(22'o17777571, 1, 0, 1, 16'h0, 1);      // byte read, odd
    xfer(22'o17777570, 1, 0, 1, 16'h0, 1);      // byte read, even
    xfer(22'o17777570, 0, 1, 0, 16'o000777, 1); // word write
    xfer(22'o17777571, 0, 1, 1, 16'h1255, 1);   // byte write, odd
    xfer(22'o17777000, 1, 0, 0, 16'h0, 0);      // NXM
    xfer(22'o17777570, 1, 0, 0, 16'h0, 5);      // late decode
    xfer(22'o17777572, 1, 0, 0, 16'h0, N);      // decode in the last allowed cycle
    xfer(22'o17777574, 0, 1, 1, 16'h8a3c, N);   // write, last allowed cycle
    xfer(22'o17777574, 0, 1, 0, 16'h1234, 0);   // write NXM
    xfer(22'o00001000, 1, 0, 0, 16'h0, 1);      // outside the I/O page
    xfer(22'o17777570, 0, 0, 0, 16'h0, 1);      // neither rd nor wr
    xfer(22'o17777570, 1, 1, 0, 16'h4321, 1);   // wr wins over rd
    xfer(22'o17777570, 1, 0, 0, 16'h0, 1);      // leave non-zero read data
    reset_mid_write();
    xfer(22'o17777570, 1, 0, 0, 16'h0, 1);      // normal timing after reset

    for (int i = 0; i < 200; i++) begin
      logic [21:0] a;
      bit rd;
      bit wr;
      a = 22'($urandom);
      if ($urandom_range(0, 3) != 0) a[21:13] = 9'o777;
      rd = 1'($urandom);
      wr = 1'($urandom);
      if ($urandom_range(0, 7) != 0 && !rd && !wr) rd = 1'b1;
      xfer(a, rd, wr, 1'($urandom), 16'($urandom), int'($urandom_range(0, N + 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, tests %0d failures %0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/iopage_ctl.md
# iopage_ctl

Bus-side initiator for the I/O page. Takes single CPU data-bus transfers, recognises the top 8 KB of 22-bit physical space (17760000–17777777 octal) and turns them into `iopage_*` read/write cycles. It then returns read data or a write acknowledge to the CPU. If no device asserts decode within a bounded window, it signals a non-existent-memory (NXM) error. Device responders such as the switch register sit on the far side; their `data_out` and `decode` outputs are OR-combined outside this block.

## Interface

- `NXM_TIMEOUT`, default 8: number of consecutive cycles without decode before NXM; legal range 1–255.

- `clk`  input  1  system clock.
- `reset`  input  1  synchronous, active-high reset.
- `cpu_req`  input  1  transfer request; sampled only in IDLE.
- `cpu_addr`  input  22  physical byte address.
- `cpu_rd`  input  1  read request.
- `cpu_wr`  input  1  write request; wins over `cpu_rd` if both are set.
- `cpu_byte_op`  input  1  byte transfer.
- `cpu_data_out`  input  16  write data from the CPU.
- `cpu_data_in`  output  16  read data to the CPU; valid while `cpu_ack`.
- `cpu_ack`  output  1  one-cycle transfer-complete pulse.
- `cpu_nxm`  output  1  one-cycle no-response pulse.
- `iopage_addr`  output  13  I/O page byte address, `cpu_addr[12:0]`.
- `iopage_data_out`  output  16  write data to devices.
- `iopage_rd`  output  1  read strobe.
- `iopage_wr`  output  1  write strobe, one cycle.
- `iopage_byte_op`  output  1  byte qualifier.
- `iopage_data_in`  input  16  OR of device read data.
- `iopage_decode`  input  1  OR of device decodes.

## Operation

- **Hit condition:** `cpu_addr[21:13] == 9'o777`. Requests outside the I/O page are ignored: no strobes, no ack, no NXM.
- **Request acceptance in IDLE:**
  - A request is accepted on `cpu_req` & hit & (`cpu_rd` | `cpu_wr`).
  - On acceptance, latch the address, the data, the byte flag and the direction (wr priority).
  - `cpu_req` is ignored in every other state.
- **States:** IDLE, ADDR, WRITE, DONE, ERR.
- **IDLE → ADDR** on accept.
- **ADDR:**
  - Drives the latched `iopage_addr` and `iopage_byte_op`.
  - Drives `iopage_rd` = 1 for reads.
  - Samples `iopage_decode` every cycle.
  - Counts no-decode cycles in an 8-bit counter, cleared on entry.
- **Decode seen in ADDR:**
  - Read: register the steered read data, then go to DONE.
  - Write: go to WRITE.
- **No decode:** the counter increments. When NXM_TIMEOUT consecutive no-decode cycles have elapsed, go to ERR.
- **WRITE:** `iopage_wr` = 1 for exactly one cycle, address and data held, `iopage_rd` = 0. Then DONE.
- **DONE:** `cpu_ack` = 1 for one cycle with `cpu_data_in` valid. Then IDLE.
- **ERR:** `cpu_nxm` = 1 for one cycle, `cpu_ack` = 0. Then IDLE.
- **Byte steering on read:**
  - Word read: `cpu_data_in` = `iopage_data_in`.
  - Byte read, even address: {8'b0, `data_in[7:0]`}.
  - Byte read, odd address: {8'b0, `data_in[15:8]`}.
- **Byte steering on write:**
  - Byte write: `iopage_data_out` = {`cpu_data_out[7:0]`, `cpu_data_out[7:0]`}.
  - Word write: `iopage_data_out` = `cpu_data_out`.
- **Outputs in IDLE:** `iopage_addr`, `iopage_data_out`, `iopage_rd`, `iopage_wr`, `iopage_byte_op` and `cpu_ack`/`cpu_nxm` are all 0.
- **`cpu_data_in` holding:** holds its last value outside DONE.

## Timing

- Cycle 0 is the IDLE cycle in which the request is accepted.
- Word or byte read with immediate decode: ADDR in cycle 1, `cpu_ack` in cycle 2.
- Write with immediate decode: ADDR in cycle 1, `iopage_wr` in cycle 2, `cpu_ack` in cycle 3.
- No decode: ADDR occupies cycles 1..NXM_TIMEOUT, and `cpu_nxm` is asserted in cycle NXM_TIMEOUT+1.
- Late decode in cycle k ≤ NXM_TIMEOUT ends the wait normally. For a read, `cpu_ack` is in cycle k+1.
- Back-to-back transfers: a new request is accepted in the IDLE cycle after DONE or ERR, giving a minimum spacing of 3 cycles for reads and 4 for writes.
- Reset asserted in any state:
  - At the next edge, the state is IDLE.
  - All outputs are 0, including `cpu_data_in`, and the counter is cleared.
  - An in-flight transfer is dropped with no ack and no NXM.
  - `iopage_wr` is never asserted during or after reset until a new request arrives.

## Test plan

- **Word read:** device model returns 0o123456 on decode of 13'o17570. Word read of 22'o17777570 → `iopage_addr` = 13'o17570 and `iopage_rd` = 1 in cycle 1; `cpu_ack` in cycle 2 with `cpu_data_in` = 0o123456.
- **Byte reads:** same device. Byte read of 22'o17777571 → `cpu_data_in` = 0o000247. Byte read of 22'o17777570 → 0o000056.
- **Word write:** word write of 0o000777 to 22'o17777570 → `iopage_wr` pulses in cycle 2 only with `iopage_data_out` = 0o000777 and `iopage_rd` = 0 throughout; `cpu_ack` in cycle 3.
- **Byte write, odd address:** data 16'h1255 to 22'o17777571 → `iopage_data_out` = 16'h5555, `iopage_byte_op` = 1, `iopage_addr[0]` = 1.
- **NXM and late decode:**
  - Read of 22'o17777000 with no decode and NXM_TIMEOUT = 8 → `cpu_nxm` in cycle 9, `cpu_ack` never asserted.
  - Decode first asserted in cycle 5 → `cpu_ack` in cycle 6.
- **Outside the I/O page and reset:**
  - Request to 22'o00001000 → no `iopage_*` activity and no ack.
  - Reset asserted in cycle 1 of a write → no `iopage_wr`, no ack, all outputs 0.
  - The next request proceeds with normal timing.
